rv_dmem: RTL and testbench

RV_DMEM -- requirements
Module: rv_dmem

---
 rtl/rv_dmem.sv | 165 ++++++++++++++++
 tb/tb_rv_dmem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem.sv
// -----------------------------------------------------------------------------
// rv_dmem_pkg / rv_dmem
//
// Single-port data memory for the core's memory stage, with an optional fixed
// number of wait states per access.
//
// Ports:
//   clk                  clock; all state updates on the rising edge
//   rst                  synchronous active-high reset
//   core2dmem_req_Q103H  request from the memory stage
//                        (wr_data, address, wr_en, rd_en, byte_en)
//   ready_Q103H          request accepted/completed this cycle
//   rd_data_Q104H        load data, valid the cycle after a read completes
//   rd_valid_Q104H       one-cycle pulse qualifying rd_data_Q104H
//   err_Q104H            one-cycle pulse: last completed request was out of
//                        range or had both rd_en and wr_en set
//   dbg_state            current FSM state, for observation only
//
// Handshake: a request is valid when rd_en or wr_en is high. It completes on
// the rising edge of a cycle in which it is valid and ready_Q103H is high;
// while ready_Q103H is low the requester holds the request stable. Responses
// (rd_valid_Q104H / err_Q104H) appear exactly one cycle after completion.
// -----------------------------------------------------------------------------
package rv_dmem_pkg;

  typedef struct packed {
    logic [31:0] wr_data;
    logic [31:0] address;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t_dmem_state;

endpackage

module rv_dmem
  import rv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  t_core2mem_req core2dmem_req_Q103H,
  output logic          ready_Q103H,
  output logic [31:0]   rd_data_Q104H,
  output logic          rd_valid_Q104H,
  output logic          err_Q104H,
  output t_dmem_state   dbg_state
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33 bits so the byte size never overflows the compare.
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  t_dmem_state   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  t_core2mem_req req_q, req_d;

  t_core2mem_req act;
  logic          live_valid;
  logic          complete;
  logic          in_range;
  logic          both_en;
  logic          is_read;
  logic [31:0]   offset;
  logic [AW-1:0] idx;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address decode operates on whichever request is completing: the latched
  // copy while waiting, the live bus otherwise.
  always_comb begin
    live_valid = core2dmem_req_Q103H.rd_en | core2dmem_req_Q103H.wr_en;
    act        = (state_q == WAIT) ? req_q : core2dmem_req_Q103H;
    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets.
    offset     = act.address - BASE_ADDR;
    in_range   = {1'b0, offset} < MEM_BYTES;
    idx        = offset[AW+1:2];
    both_en    = act.rd_en & act.wr_en;
    // A request with both enables is handled as a write only.
    is_read    = act.rd_en & ~act.wr_en;
  end

  // Next-state / handshake logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    ready_Q103H = 1'b1;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (live_valid) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            ready_Q103H = 1'b0;
            req_d       = core2dmem_req_Q103H;
            cnt_d       = 4'(WAIT_STATES - 1);
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          ready_Q103H = 1'b0;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Memory array is intentionally not reset; rst only blocks a write that
  // would otherwise complete on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && complete && act.wr_en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (act.byte_en[i]) begin
          mem[idx][8*i +: 8] <= act.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Response registers. rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_Q104H  <= 32'd0;
      rd_valid_Q104H <= 1'b0;
      err_Q104H      <= 1'b0;
    end else begin
      rd_valid_Q104H <= complete & is_read;
      err_Q104H      <= complete & (~in_range | both_en);
      if (complete && is_read) begin
        rd_data_Q104H <= in_range ? mem[idx] : 32'd0;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_dmem.sv
module tb_rv_dmem;
  import rv_dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs: zero and three wait states ----------------
  t_core2mem_req req0, req3;
  logic          ready0, ready3, rv0, rv3, err0, err3;
  logic [31:0]   rd0, rd3;
  t_dmem_state   st0, st3;

  rv_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .core2dmem_req_Q103H(req0), .ready_Q103H(ready0),
    .rd_data_Q104H(rd0), .rd_valid_Q104H(rv0), .err_Q104H(err0), .dbg_state(st0)
  );

  rv_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .core2dmem_req_Q103H(req3), .ready_Q103H(ready3),
    .rd_data_Q104H(rd3), .rd_valid_Q104H(rv3), .err_Q104H(err3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  // entry = {response cycle[31:0], rd_valid, err, rd_data[31:0]}
  logic [65:0] exp_q0[$];
  logic [65:0] exp_q3[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [65:0] e;
    if (rv0 || err0) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected response: rd_valid=%b err=%b expected none", rv0, err0);
      end else begin
        e = exp_q0.pop_front();
        check("dut0 response cycle", cyc, e[65:34]);
        check("dut0 rd_valid/err", {30'd0, rv0, err0}, {30'd0, e[33:32]});
        if (e[33]) check("dut0 rd_data", rd0, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [65:0] e;
    if (rv3 || err3) begin
      if (exp_q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected response: rd_valid=%b err=%b expected none", rv3, err3);
      end else begin
        e = exp_q3.pop_front();
        check("dut3 response cycle", cyc, e[65:34]);
        check("dut3 rd_valid/err", {30'd0, rv3, err3}, {30'd0, e[33:32]});
        if (e[33]) check("dut3 rd_data", rd3, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one request and holds it until ready is seen high; pushes the
  // expected response at acceptance and checks the number of stall cycles.
  task automatic access(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                        input bit wr, input bit rd, input logic [3:0] be,
                        input int exp_low, input bit exp_err, input logic [31:0] exp_rd);
    t_core2mem_req r;
    int  lows = 0;
    bit  rdy  = 1'b0;
    bit  exp_valid;
    logic [65:0] e;
    r.wr_data = data; r.address = addr; r.wr_en = wr; r.rd_en = rd; r.byte_en = be;
    exp_valid = rd && !wr;
    if (sel) req3 = r; else req0 = r;
    while (!rdy && lows < 20) begin
      @(negedge clk);
      rdy = sel ? ready3 : ready0;
      if (!rdy) lows++;
      else if (exp_valid || exp_err) begin
        e = {32'(cyc + 1), exp_valid, exp_err, exp_rd};
        if (sel) exp_q3.push_back(e); else exp_q0.push_back(e);
      end
      @(posedge clk); #1;
    end
    check($sformatf("dut%0d ready low cycles @%h", sel ? 3 : 0, addr), lows, exp_low);
  endtask

  task automatic idle(input int n);
    req0 = '0;
    req3 = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int t0;

  initial begin
    req0 = '0;
    req3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state, first cycle after rst deasserts
    @(negedge clk);
    check("reset ready0", {31'd0, ready0}, 32'd1);
    check("reset ready3", {31'd0, ready3}, 32'd1);
    check("reset rd_data0", rd0, 32'd0);
    check("reset rd_valid/err0", {30'd0, rv0, err0}, 32'd0);
    check("reset rd_valid/err3", {30'd0, rv3, err3}, 32'd0);
    check("reset state3", 32'(st3), 32'(IDLE));
    @(posedge clk); #1;

    // zero wait states: back-to-back write then read, no bubble
    t0 = cyc;
    access(0, 32'h2004, 32'hDEADBEEF, 1, 0, 4'hF, 0, 0, 32'h0);
    access(0, 32'h2004, 32'h0,        0, 1, 4'hF, 0, 0, 32'hDEADBEEF);
    check("dut0 back-to-back cycles", cyc - t0, 32'd2);
    idle(3);
    check("dut0 rd_data hold", rd0, 32'hDEADBEEF);
    check("dut0 rd_valid idle", {31'd0, rv0}, 32'd0);

    // byte lanes
    access(0, 32'h2008, 32'h11223344, 1, 0, 4'hF,    0, 0, 32'h0);
    access(0, 32'h2008, 32'hAABBCCDD, 1, 0, 4'b0101, 0, 0, 32'h0);
    access(0, 32'h2008, 32'h0,        0, 1, 4'hF,    0, 0, 32'h11BB33DD);

    // byte_en = 0 write changes nothing and raises no error
    access(0, 32'h200C, 32'h12345678, 1, 0, 4'hF, 0, 0, 32'h0);
    access(0, 32'h200C, 32'hFFFFFFFF, 1, 0, 4'h0, 0, 0, 32'h0);
    access(0, 32'h200C, 32'h0,        0, 1, 4'hF, 0, 0, 32'h12345678);

    // range: words that a wrapped index would alias
    access(0, 32'h2000, 32'hA0A0A0A0, 1, 0, 4'hF, 0, 0, 32'h0);
    access(0, 32'h2FFC, 32'hB0B0B0B0, 1, 0, 4'hF, 0, 0, 32'h0);
    access(0, 32'h1FFC, 32'h0,        0, 1, 4'hF, 0, 1, 32'h0);
    access(0, 32'h3000, 32'h0,        0, 1, 4'hF, 0, 1, 32'h0);
    access(0, 32'h1FFC, 32'hFFFFFFFF, 1, 0, 4'hF, 0, 1, 32'h0);
    access(0, 32'h3000, 32'hFFFFFFFF, 1, 0, 4'hF, 0, 1, 32'h0);
    access(0, 32'h2000, 32'h0,        0, 1, 4'hF, 0, 0, 32'hA0A0A0A0);
    access(0, 32'h2FFC, 32'h0,        0, 1, 4'hF, 0, 0, 32'hB0B0B0B0);

    // both enables: write only, error, no rd_valid
    access(0, 32'h2010, 32'h5A5A5A5A, 1, 1, 4'hF, 0, 1, 32'h0);
    access(0, 32'h2010, 32'h0,        0, 1, 4'hF, 0, 0, 32'h5A5A5A5A);
    idle(2);

    // three wait states
    access(1, 32'h2004, 32'h01020304, 1, 0, 4'hF, 3, 0, 32'h0);
    access(1, 32'h2008, 32'h55667788, 1, 0, 4'hF, 3, 0, 32'h0);
    t0 = cyc;
    access(1, 32'h2004, 32'h0, 0, 1, 4'hF, 3, 0, 32'h01020304);
    access(1, 32'h2008, 32'h0, 0, 1, 4'hF, 3, 0, 32'h55667788);
    check("dut3 back-to-back cycles", cyc - t0, 32'd8);
    access(1, 32'h3000, 32'h0, 0, 1, 4'hF, 3, 1, 32'h0);
    idle(2);

    // completion must use the latched request, not the live bus
    req3 = '{wr_data: 32'h77777777, address: 32'h200C, wr_en: 1'b1, rd_en: 1'b0, byte_en: 4'hF};
    @(posedge clk); #1;
    req3 = '{wr_data: 32'hFFFFFFFF, address: 32'h2004, wr_en: 1'b1, rd_en: 1'b0, byte_en: 4'hF};
    repeat (3) @(posedge clk);
    #1 req3 = '0;
    access(1, 32'h200C, 32'h0, 0, 1, 4'hF, 3, 0, 32'h77777777);
    access(1, 32'h2004, 32'h0, 0, 1, 4'hF, 3, 0, 32'h01020304);
    idle(2);

    // reset during a pending write aborts it
    access(1, 32'h2000, 32'hCAFEF00D, 1, 0, 4'hF, 3, 0, 32'h0);
    req3 = '{wr_data: 32'h0BADBEEF, address: 32'h2000, wr_en: 1'b1, rd_en: 1'b0, byte_en: 4'hF};
    @(posedge clk); #1;
    rst  = 1'b1;
    req3 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort state3", 32'(st3), 32'(IDLE));
    check("abort ready3", {31'd0, ready3}, 32'd1);
    check("abort rd_valid/err3", {30'd0, rv3, err3}, 32'd0);
    @(posedge clk); #1;
    idle(4);
    access(1, 32'h2000, 32'h0, 0, 1, 4'hF, 3, 0, 32'hCAFEF00D);
    idle(4);

    check("dut0 pending responses", exp_q0.size(), 32'd0);
    check("dut3 pending responses", exp_q3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
